// File: rtl/serout_tx_sequencer_pkg.sv
// serout_tx_sequencer_pkg: state encoding and frame geometry shared by the SEROUT/SERIN sequencers
package serout_tx_sequencer_pkg;
  typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_e;
  localparam int FRAME_BITS_DEF = 10;
  localparam int CNT_W_DEF = 4;
endpackage

// File: rtl/serout_tx_sequencer_frame_counter.sv
// serout_frame_counter: bit-time counter with clear, increment and terminal-count flag
module serout_frame_counter #(
  parameter int CNT_W = 4,
  parameter int FRAME_BITS = 10
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic inc_i,
  output logic tc_o
);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  always_comb cnt_d = clr_i ? '0 : inc_i ? cnt_q + 1'b1 : cnt_q;
  always_ff @(posedge clk)
    if (rst) cnt_q <= '0;
    else cnt_q <= cnt_d;
  assign tc_o = cnt_q == CNT_W'(FRAME_BITS - 1);
endmodule

// File: rtl/serout_tx_sequencer.sv
// serout_tx_sequencer: turns baud ticks into load/shift strobes and tracks the SEROUT holding register
module serout_tx_sequencer
  import serout_tx_sequencer_pkg::*;
#(
  parameter int FRAME_BITS = FRAME_BITS_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic enp,
  input  logic wr_serout,
  input  logic bit_tick,
  output logic load,
  output logic shift,
  output logic odn_pulse,
  output logic tx_done,
  output logic overrun,
  output logic busy
);
  state_e state_q, state_d;
  logic pending_q, pending_d, odn_q, ovr_q, txd_q;
  logic tk, wr, tc, at_end;
  assign tk = enp & bit_tick & ~reset;
  assign wr = wr_serout & enp;
  // a frame boundary is either idle or the stop bit finishing its bit time
  assign at_end = (state_q == IDLE) | tc;
  always_comb begin
    load = tk & at_end & pending_q;
    shift = tk & (state_q == SHIFT) & ~tc;
    state_d = (tk & at_end) ? (pending_q ? SHIFT : IDLE) : state_q;
    pending_d = load ? wr : pending_q | wr;
  end
  serout_frame_counter #(.CNT_W(CNT_W), .FRAME_BITS(FRAME_BITS)) u_cnt (
    .clk  (clk),
    .rst  (reset),
    .clr_i(tk & at_end),
    .inc_i(shift),
    .tc_o (tc)
  );
  always_ff @(posedge clk)
    if (reset) begin
      state_q <= IDLE;
      pending_q <= 1'b0;
      odn_q <= 1'b0;
      ovr_q <= 1'b0;
      txd_q <= 1'b1;
    end else begin
      state_q <= state_d;
      pending_q <= pending_d;
      odn_q <= load;
      ovr_q <= wr & pending_q & ~load;
      txd_q <= (state_d == IDLE) & ~pending_d;
    end
  assign odn_pulse = odn_q;
  assign overrun = ovr_q;
  assign tx_done = txd_q;
  assign busy = state_q == SHIFT;
endmodule

// File: tb/tb_serout_tx_sequencer.sv
// tb_serout_tx_sequencer: scenario and random stimulus checked against a frame-level reference model
module tb_serout_tx_sequencer;
  logic clk = 0, reset = 1, enp = 0, wr_serout = 0, bit_tick = 0;
  logic load, shift, odn_pulse, tx_done, overrun, busy;
  int checks = 0, failures = 0;
  int n_load = 0, n_shift = 0, n_odn = 0, n_ovr = 0;
  int b_load, b_shift, b_odn, b_ovr;
  bit chk_en = 0;
  bit m_pend = 0, m_odn = 0, m_ovr = 0;
  int m_remain = 0;

  serout_tx_sequencer dut (
    .clk(clk), .reset(reset), .enp(enp), .wr_serout(wr_serout), .bit_tick(bit_tick),
    .load(load), .shift(shift), .odn_pulse(odn_pulse), .tx_done(tx_done),
    .overrun(overrun), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0b expected=%0b t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk_n(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
    end
  endtask

  // Reference: m_remain is the number of ticks left before the current frame ends (0 = idle).
  always @(negedge clk) if (chk_en) begin
    bit tk, w, e_load, e_shift;
    tk = enp & bit_tick & ~reset;
    w = wr_serout & enp;
    e_load = tk && m_remain <= 1 && m_pend;
    e_shift = tk && m_remain >= 2;
    chk("load", load, e_load);
    chk("shift", shift, e_shift);
    chk("odn_pulse", odn_pulse, m_odn);
    chk("overrun", overrun, m_ovr);
    chk("busy", busy, m_remain > 0);
    chk("tx_done", tx_done, m_remain == 0 && !m_pend);
    n_load += int'(load);
    n_shift += int'(shift);
    n_odn += int'(odn_pulse);
    n_ovr += int'(overrun);
    if (reset) begin
      m_pend = 0; m_remain = 0; m_odn = 0; m_ovr = 0;
    end else begin
      m_ovr = w && m_pend && !e_load;
      m_odn = e_load;
      if (e_load) m_remain = 10;
      else if (e_shift) m_remain--;
      else if (tk && m_remain == 1) m_remain = 0;
      m_pend = e_load ? w : (m_pend | w);
    end
  end

  task automatic step(input bit e, input bit w, input bit t, input bit r);
    @(posedge clk);
    #1;
    enp = e; wr_serout = w & e; bit_tick = t; reset = r;
  endtask

  task automatic mark();
    b_load = n_load; b_shift = n_shift; b_odn = n_odn; b_ovr = n_ovr;
  endtask

  task automatic expect_counts(input string nm, input int el, input int es, input int eo, input int ev);
    chk_n({nm, "_loads"}, n_load - b_load, el);
    chk_n({nm, "_shifts"}, n_shift - b_shift, es);
    chk_n({nm, "_odn"}, n_odn - b_odn, eo);
    chk_n({nm, "_overrun"}, n_ovr - b_ovr, ev);
  endtask

  // tick every 16 clks; up to three writes; optional reset cycle; gate masks every other tick with enp=0
  task automatic run(input int n, input int w1, input int w2, input int w3, input int rc, input bit gate);
    for (int i = 0; i < n; i++) begin
      bit e;
      e = !(gate && (i % 16) == 7);
      step(e, i == w1 || i == w2 || i == w3, gate ? (i % 8) == 7 : (i % 16) == 15, i == rc);
    end
  endtask

  initial begin
    step(0, 0, 0, 1);
    step(0, 0, 0, 1);
    chk_en = 1;
    step(0, 0, 1, 1);
    step(1, 0, 0, 0);
    chk("rst_tx_done", tx_done, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_odn", odn_pulse, 1'b0);
    chk("rst_overrun", overrun, 1'b0);

    mark(); run(192, 10, -1, -1, -1, 0);
    expect_counts("single", 1, 9, 1, 0);
    chk("single_done", tx_done, 1'b1);

    mark(); run(384, 10, 70, -1, -1, 0);
    expect_counts("b2b", 2, 18, 2, 0);

    mark(); run(384, 10, 60, 90, -1, 0);
    expect_counts("ovr", 2, 18, 2, 1);

    mark(); run(384, 5, 15, -1, -1, 0);
    expect_counts("coinc", 2, 18, 2, 0);

    mark(); run(300, 10, -1, -1, 100, 0);
    expect_counts("rstmid", 1, 5, 1, 0);
    chk("rstmid_busy", busy, 1'b0);
    chk("rstmid_done", tx_done, 1'b1);
    mark(); run(192, 10, -1, -1, -1, 0);
    expect_counts("after_rst", 1, 9, 1, 0);

    mark(); run(200, 10, -1, -1, -1, 1);
    expect_counts("gate", 1, 9, 1, 0);

    for (int i = 0; i < 5000; i++)
      step($urandom_range(0, 3) != 0, $urandom_range(0, 59) == 0, $urandom_range(0, 9) == 0,
           $urandom_range(0, 799) == 0);
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
